addsub_arbiter: RTL and testbench

- Shares one saturating 16-bit adder/subtractor (addsub_16bit) among NUM_REQ requesters, for example decode-stage ALU ops and a PC/offset helper.
- Arbitration is round-robin. Each requester uses a valid/ready handshake on request and on response.
- Operands are registered, then the sum is registered. The saturated result and a saturation flag go back to the granted requester.
- Serves one operation at a time: no pipelining between operations.

---
 rtl/addsub_arbiter_pkg.sv | 15 +
 rtl/addsub_16bit.sv | 13 +
 rtl/addsub_arbiter.sv | 73 +++++++
 tb/tb_addsub_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_arbiter_pkg.sv
// addsub_arbiter_pkg: state encoding, saturation limits and exact-range helpers for the shared adder
package addsub_arbiter_pkg;
  localparam int DW = 16;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] EXEC = 2'b01;
  localparam logic [1:0] RESP = 2'b10;
  localparam logic [DW-1:0] SAT_POS = 16'h7FFF;
  localparam logic [DW-1:0] SAT_NEG = 16'h8000;
  function automatic logic [DW:0] exact(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sub);
    return sub ? {a[DW-1], a} - {b[DW-1], b} : {a[DW-1], a} + {b[DW-1], b};
  endfunction
  function automatic logic ovf(input logic [DW:0] e);
    return e[DW] ^ e[DW-1];
  endfunction
endpackage

// File: rtl/addsub_16bit.sv
// addsub_16bit: saturating signed 16-bit add/subtract
module addsub_16bit import addsub_arbiter_pkg::*; (
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic          sub,
  output logic [DW-1:0] SUM
);
  logic [DW:0] e;
  always_comb begin
    e = exact(A, B, sub);
    SUM = ovf(e) ? (e[DW] ? SAT_NEG : SAT_POS) : e[DW-1:0];
  end
endmodule

// File: rtl/addsub_arbiter.sv
// addsub_arbiter: round-robin sharing of one saturating adder/subtractor among NUM_REQ requesters
module addsub_arbiter import addsub_arbiter_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int GW = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [DW*NUM_REQ-1:0] req_a,
  input  logic [DW*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_sub,
  output logic [NUM_REQ-1:0]    resp_valid,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic [DW-1:0]         resp_data,
  output logic                  resp_sat,
  output logic                  busy
);
  logic [1:0] state;
  logic [GW-1:0] rr_ptr, grant, pick;
  logic hit, sub_r;
  logic [DW-1:0] a_r, b_r, sum;
  // closest valid requester at or after p, wrapping modulo NUM_REQ
  function automatic logic [GW:0] rr_pick(input logic [NUM_REQ-1:0] v, input logic [GW-1:0] p);
    logic [GW:0] r;
    int best, d;
    r = '0;
    best = NUM_REQ;
    for (int j = 0; j < NUM_REQ; j++) begin
      d = (j + NUM_REQ - int'(p)) % NUM_REQ;
      if (v[j] && d < best) begin
        best = d;
        r = {1'b1, GW'(j)};
      end
    end
    return r;
  endfunction
  assign {hit, pick} = rr_pick(req_valid, rr_ptr);
  assign req_ready = (rst_n && state == IDLE && hit) ? NUM_REQ'(1) << pick : '0;
  assign resp_valid = (state == RESP) ? NUM_REQ'(1) << grant : '0;
  assign busy = state != IDLE;
  addsub_16bit u_addsub (.A(a_r), .B(b_r), .sub(sub_r), .SUM(sum));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      grant <= '0;
      a_r <= '0;
      b_r <= '0;
      sub_r <= 1'b0;
      resp_data <= '0;
      resp_sat <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hit) begin
          a_r <= req_a[pick*DW +: DW];
          b_r <= req_b[pick*DW +: DW];
          sub_r <= |(req_sub & req_ready);
          grant <= pick;
          rr_ptr <= GW'((int'(pick) + 1) % NUM_REQ);
          state <= EXEC;
        end
        EXEC: begin
          resp_data <= sum;
          resp_sat <= ovf(exact(a_r, b_r, sub_r));
          state <= RESP;
        end
        RESP: if (|(resp_ready & resp_valid)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_arbiter.sv
// tb_addsub_arbiter: directed and randomized checks of addsub_arbiter against a transaction-level model
module tb_addsub_arbiter;
  localparam int N = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_sub = '0, resp_ready = '0, req_ready, resp_valid;
  logic [16*N-1:0] req_a = '0, req_b = '0;
  logic [15:0] resp_data;
  logic resp_sat, busy;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  addsub_arbiter #(.NUM_REQ(N), .GW(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_sat(resp_sat), .busy(busy)
  );
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", n, act, exp, $time);
    end
  endtask
  function automatic int rr_find(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  function automatic logic [16:0] ref_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    int sa, sb, e;
    logic [15:0] d;
    sa = int'($signed(a));
    sb = int'($signed(b));
    e = s ? sa - sb : sa + sb;
    d = e > 32767 ? 16'h7FFF : e < -32768 ? 16'h8000 : e[15:0];
    return {(e > 32767 || e < -32768), d};
  endfunction
  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction
  // model: m_age -1 = free, 0 = operation accepted last edge, 1 = response outstanding
  int m_ptr = 0, m_owner = 0, m_age = -1, m_ops = 0, m_pick;
  logic [15:0] m_data = '0;
  logic m_sat = 1'b0;
  assign m_pick = rr_find(req_valid, m_ptr);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0;
      m_age <= -1;
      m_owner <= 0;
    end else if (m_age < 0 && m_pick >= 0) begin
      m_owner <= m_pick;
      m_ptr <= (m_pick + 1) % N;
      m_age <= 0;
      m_ops <= m_ops + 1;
      {m_sat, m_data} <= ref_op(req_a[16*m_pick +: 16], req_b[16*m_pick +: 16], req_sub[m_pick]);
    end else if (m_age == 0) m_age <= 1;
    else if (m_age == 1 && resp_ready[m_owner]) m_age <= -1;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_data", 32'(resp_data), 0);
      chk("rst_sat", 32'(resp_sat), 0);
    end else begin
      chk("req_ready", 32'(req_ready), (m_age < 0 && m_pick >= 0) ? 32'(1) << m_pick : 0);
      chk("resp_valid", 32'(resp_valid), m_age == 1 ? 32'(1) << m_owner : 0);
      chk("busy", 32'(busy), 32'(m_age >= 0));
      chk("onehot", {30'd0, $onehot0(req_ready), $onehot0(resp_valid)}, 3);
      if (m_age == 1) begin
        chk("resp_data", 32'(resp_data), 32'(m_data));
        chk("resp_sat", 32'(resp_sat), 32'(m_sat));
      end
    end
  end
  task automatic op(input int r, input logic [15:0] a, input logic [15:0] b, input logic s,
                    input logic [15:0] ed, input logic es);
    int k;
    req_valid[r] = 1'b1;
    req_a[16*r +: 16] = a;
    req_b[16*r +: 16] = b;
    req_sub[r] = s;
    resp_ready = '1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!req_ready[r] && k < 20);
    chk("op_accept", 32'(req_ready[r]), 1);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
    @(negedge clk);
    chk("op_lat_exec", 32'(resp_valid), 0);
    @(negedge clk);
    chk("op_resp_valid", 32'(resp_valid), 32'(1) << r);
    chk("op_data", 32'(resp_data), 32'(ed));
    chk("op_sat", 32'(resp_sat), 32'(es));
    @(posedge clk);
    #1;
  endtask
  initial begin
    int gq[$];
    int nresp, start, cyc;
    logic [N-1:0] rdy;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    op(0, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0);
    op(0, 16'h7000, 16'h2000, 1'b0, 16'h7FFF, 1'b1);
    op(0, 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1);
    op(1, 16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b1);
    op(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
    op(1, 16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1);
    // contention with both requesters held valid out of reset
    rst_n = 1'b0;
    req_valid = 2'b11;
    req_a = {16'd9, 16'd5};
    req_b = {16'd4, 16'd3};
    req_sub = 2'b10;
    resp_ready = '1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (req_ready != 0) gq.push_back(req_ready == 2'b10 ? 1 : 0);
      if (resp_valid == 2'b01) chk("cont_r0_data", 32'(resp_data), 32'h8);
      if (resp_valid == 2'b10) chk("cont_r1_data", 32'(resp_data), 32'h5);
    end
    chk("cont_grants", 32'(gq.size() >= 4), 1);
    for (int i = 0; i < 4 && i < gq.size(); i++) chk("cont_order", 32'(gq[i]), 32'(i % 2));
    // backpressure with requester 1 pending
    @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = '0;
    resp_ready = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    req_valid = 2'b11;
    req_a = {16'd7, 16'd1};
    req_b = {16'd7, 16'd2};
    req_sub = '0;
    @(negedge clk);
    chk("bp_grant", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("bp_resp_valid", 32'(resp_valid), 1);
      chk("bp_data", 32'(resp_data), 3);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_req_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
    resp_ready = '1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_next", 32'(req_ready), 2);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset while an operation is in EXEC
    req_valid[0] = 1'b1;
    req_a[15:0] = 16'd100;
    req_b[15:0] = 16'd200;
    @(negedge clk);
    chk("rst_grant", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_resp_valid", 32'(resp_valid), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_data", 32'(resp_data), 0);
    chk("async_sat", 32'(resp_sat), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    nresp = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid != 0) nresp++;
    end
    chk("rst_no_resp", 32'(nresp), 0);
    @(posedge clk);
    #1 req_valid = 2'b11;
    @(negedge clk);
    chk("rst_first_r0", 32'(req_ready), 1);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #1;
    // randomized mix
    start = m_ops;
    cyc = 0;
    while (m_ops - start < 200 && cyc < 20000) begin
      @(negedge clk);
      rdy = req_ready;
      @(posedge clk);
      #1 cyc++;
      for (int i = 0; i < N; i++) begin
        if (rdy[i] || !req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) != 0);
          req_a[16*i +: 16] = rnd16();
          req_b[16*i +: 16] = rnd16();
          req_sub[i] = 1'($urandom_range(0, 1));
        end else if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      end
      resp_ready = N'($urandom);
    end
    chk("rand_ops", 32'(m_ops - start >= 200), 1);
    req_valid = '0;
    resp_ready = '1;
    repeat (5) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
